// File: rtl/eject_scheduler_if.sv
// Bundle of ejection-stage signals between the router/PE side and the eject scheduler.
// The master side drives the four candidate flits, their valids and the PE ready.
interface eject_scheduler_if #(
    parameter int unsigned FLIT_W = 64,
    parameter int unsigned CNT_W  = 16
);
    logic [FLIT_W-1:0] flit_in0;
    logic [FLIT_W-1:0] flit_in1;
    logic [FLIT_W-1:0] flit_in2;
    logic [FLIT_W-1:0] flit_in3;
    logic [3:0]        in_valid;
    logic [3:0]        eject_grant;
    logic [FLIT_W-1:0] pe_flit;
    logic              pe_valid;
    logic              pe_ready;
    logic              fifo_full;
    logic [CNT_W-1:0]  eject_count;

    modport master (
        output flit_in0, flit_in1, flit_in2, flit_in3, in_valid, pe_ready,
        input  eject_grant, pe_flit, pe_valid, fifo_full, eject_count
    );

    modport slave (
        input  flit_in0, flit_in1, flit_in2, flit_in3, in_valid, pe_ready,
        output eject_grant, pe_flit, pe_valid, fifo_full, eject_count
    );
endinterface

// File: rtl/eject_scheduler.sv
// Local ejection: oldest-first arbitration with round-robin tie break into a small FIFO
// drained by the PE over valid/ready. Head flit and status flags are registered.
module eject_scheduler #(
    parameter int unsigned FLIT_W    = 64,
    parameter int unsigned LOCAL_BIT = 0,
    parameter int unsigned AGE_LSB   = 8,
    parameter int unsigned AGE_W     = 8,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    eject_scheduler_if.slave bus
);
    localparam int unsigned NIN   = 4;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [FLIT_W-1:0] flit [NIN];
    logic [FLIT_W-1:0] mem  [DEPTH];
    logic [NIN-1:0]    req;
    logic [NIN-1:0]    tie;
    logic [NIN-1:0]    grant;
    logic [AGE_W-1:0]  max_age;
    logic [1:0]        rr_ptr;
    logic [1:0]        idx;
    logic [1:0]        gidx;
    logic              found;
    logic              push;
    logic              pop;
    logic              can_push;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_next;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_next;
    logic [FLIT_W-1:0] flit_sel;
    logic [FLIT_W-1:0] head_q;
    logic [FLIT_W-1:0] head_next;
    logic              valid_q;
    logic              full_q;
    logic [CNT_W-1:0]  count_q;

    assign flit[0] = bus.flit_in0;
    assign flit[1] = bus.flit_in1;
    assign flit[2] = bus.flit_in2;
    assign flit[3] = bus.flit_in3;

    always_comb begin
        req = '0;
        for (int i = 0; i < NIN; i++) begin
            req[i] = bus.in_valid[i] & flit[i][LOCAL_BIT];
        end
    end

    assign pop      = valid_q & bus.pe_ready;
    assign can_push = (occ < OCC_W'(DEPTH)) | pop;

    // Oldest requester wins; ties resolved by first match scanning up from rr_ptr.
    always_comb begin
        max_age = '0;
        tie     = '0;
        grant   = '0;
        gidx    = '0;
        idx     = '0;
        found   = 1'b0;
        for (int i = 0; i < NIN; i++) begin
            if (req[i] && (flit[i][AGE_LSB +: AGE_W] > max_age)) begin
                max_age = flit[i][AGE_LSB +: AGE_W];
            end
        end
        for (int i = 0; i < NIN; i++) begin
            tie[i] = req[i] && (flit[i][AGE_LSB +: AGE_W] == max_age);
        end
        for (int k = 0; k < NIN; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && tie[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found && can_push && reset) begin
            grant[gidx] = 1'b1;
        end
    end

    assign push     = |grant;
    assign flit_sel = flit[gidx];
    assign rd_next  = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + OCC_W'(1);
            2'b01:   occ_next = occ - OCC_W'(1);
            default: occ_next = occ;
        endcase
    end

    // Next head: a push lands on the head slot only when the FIFO is otherwise empty.
    always_comb begin
        head_next = mem[rd_next];
        if (occ_next == '0) begin
            head_next = '0;
        end else if (push && (wr_ptr == rd_next)) begin
            head_next = flit_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= flit_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            occ     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rr_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            head_q  <= '0;
        end else begin
            occ     <= occ_next;
            rd_ptr  <= rd_next;
            count_q <= count_q + CNT_W'(push);
            valid_q <= (occ_next != '0);
            full_q  <= (occ_next == OCC_W'(DEPTH));
            head_q  <= head_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr_ptr <= gidx + 2'd1;
            end
        end
    end

    assign bus.eject_grant = grant;
    assign bus.pe_flit     = head_q;
    assign bus.pe_valid    = valid_q;
    assign bus.fifo_full   = full_q;
    assign bus.eject_count = count_q;
endmodule

// File: tb/tb_eject_scheduler.sv
// Bench for eject_scheduler: queue-based reference model checked every cycle plus
// directed vectors with hand-derived expectations. A second instance shares stimulus but not reset.
module tb_eject_scheduler;
    localparam int unsigned FLIT_W = 64;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DEPTH  = 2;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    eject_scheduler_if #(.FLIT_W(FLIT_W), .CNT_W(CNT_W)) ifa ();
    eject_scheduler_if #(.FLIT_W(FLIT_W), .CNT_W(CNT_W)) ifb ();

    assign ifb.flit_in0 = ifa.flit_in0;
    assign ifb.flit_in1 = ifa.flit_in1;
    assign ifb.flit_in2 = ifa.flit_in2;
    assign ifb.flit_in3 = ifa.flit_in3;
    assign ifb.in_valid = ifa.in_valid;
    assign ifb.pe_ready = ifa.pe_ready;

    eject_scheduler dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
    eject_scheduler dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input bit loc, input logic [7:0] age, input logic [47:0] tag);
        return {tag, age, 7'd0, loc};
    endfunction

    function automatic logic [63:0] flit_of(input int i);
        case (i)
            0:       return ifa.flit_in0;
            1:       return ifa.flit_in1;
            2:       return ifa.flit_in2;
            default: return ifa.flit_in3;
        endcase
    endfunction

    // Reference state: FIFO contents as a queue, ejection total, round-robin start.
    logic [63:0] mq [$];
    int unsigned m_cnt = 0;
    int          m_rr  = 0;
    bit          chk_en = 1'b0;

    function automatic logic [3:0] model_grant();
        int  best = -1;
        int  win  = -1;
        bit  room;
        logic [63:0] f;
        room = (mq.size() < DEPTH) || (ifa.pe_ready === 1'b1);
        if (rst_a !== 1'b1 || !room) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            int i;
            int a;
            i = (m_rr + k) % 4;
            f = flit_of(i);
            if (ifa.in_valid[i] && f[0]) begin
                a = int'(f[15:8]);
                if (a > best) begin
                    best = a;
                    win  = i;
                end
            end
        end
        if (win < 0) return 4'b0000;
        return 4'b0001 << win;
    endfunction

    always @(negedge clk) begin : compare
        logic [3:0] g;
        int         w;
        g = model_grant();
        if (chk_en) begin
            chk("eject_grant", 64'(ifa.eject_grant), 64'(g));
            chk("pe_valid", 64'(ifa.pe_valid), 64'(mq.size() != 0));
            chk("pe_flit", ifa.pe_flit, (mq.size() != 0) ? mq[0] : 64'h0);
            chk("fifo_full", 64'(ifa.fifo_full), 64'(mq.size() == DEPTH));
            chk("eject_count", 64'(ifa.eject_count), 64'(m_cnt));
        end
        if (rst_a !== 1'b1) begin
            mq.delete();
            m_cnt = 0;
            m_rr  = 0;
        end else begin
            if (mq.size() != 0 && ifa.pe_ready) void'(mq.pop_front());
            if (g != 4'b0000) begin
                w = 0;
                for (int i = 0; i < 4; i++) if (g[i]) w = i;
                mq.push_back(flit_of(w));
                m_cnt = (m_cnt + 1) % 65536;
                m_rr  = (w + 1) % 4;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set4(input logic [3:0] v, input logic [63:0] f0, input logic [63:0] f1,
                        input logic [63:0] f2, input logic [63:0] f3);
        ifa.in_valid = v;
        ifa.flit_in0 = f0;
        ifa.flit_in1 = f1;
        ifa.flit_in2 = f2;
        ifa.flit_in3 = f3;
    endtask

    task automatic drain();
        ifa.in_valid = 4'b0000;
        ifa.pe_ready = 1'b1;
        repeat (3) cyc();
        ifa.pe_ready = 1'b0;
    endtask

    logic [63:0] rrf [4];
    int guard;

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        ifa.pe_ready = 1'b0;
        set4(4'b0000, 64'h0, 64'h0, 64'h0, 64'h0);
        cyc();
        cyc();
        rst_a = 1'b1;
        rst_b = 1'b1;
        chk_en = 1'b1;
        chk("reset pe_valid", 64'(ifa.pe_valid), 64'd0);
        chk("reset fifo_full", 64'(ifa.fifo_full), 64'd0);
        chk("reset eject_count", 64'(ifa.eject_count), 64'd0);
        chk("reset pe_flit", ifa.pe_flit, 64'd0);

        // Single request on input 2
        set4(4'b0100, 64'h0, 64'h0, mk(1, 8'd5, 48'h22), 64'h0);
        #2;
        chk("single grant", 64'(ifa.eject_grant), 64'b0100);
        cyc();
        ifa.in_valid = 4'b0000;
        chk("single pe_valid", 64'(ifa.pe_valid), 64'd1);
        chk("single pe_flit", ifa.pe_flit, mk(1, 8'd5, 48'h22));
        chk("single eject_count", 64'(ifa.eject_count), 64'd1);
        chk("single model rr", 64'(m_rr), 64'd3);
        drain();

        // Age priority: ages 3,9,9,1 from rr 0 then rr 2
        ifa.pe_ready = 1'b1;
        set4(4'b1000, 64'h0, 64'h0, 64'h0, mk(1, 8'd0, 48'h33));
        cyc();
        set4(4'b1111, mk(1, 8'd3, 48'h10), mk(1, 8'd9, 48'h11), mk(1, 8'd9, 48'h12), mk(1, 8'd1, 48'h13));
        #2;
        chk("age rr0 grant", 64'(ifa.eject_grant), 64'b0010);
        chk("age rr0 model", 64'(model_grant()), 64'b0010);
        cyc();
        #2;
        chk("age rr2 model rr", 64'(m_rr), 64'd2);
        chk("age rr2 grant", 64'(ifa.eject_grant), 64'b0100);
        cyc();
        drain();

        // Round-robin over four equal-age requesters
        ifa.pe_ready = 1'b1;
        set4(4'b1000, 64'h0, 64'h0, 64'h0, mk(1, 8'd0, 48'h33));
        cyc();
        for (int i = 0; i < 4; i++) rrf[i] = mk(1, 8'd0, 48'hA0 + 48'(i));
        set4(4'b1111, rrf[0], rrf[1], rrf[2], rrf[3]);
        for (int i = 0; i < 8; i++) begin
            #2;
            chk("rr grant", 64'(ifa.eject_grant), 64'(4'b0001 << (i % 4)));
            cyc();
            chk("rr pe_flit", ifa.pe_flit, rrf[i % 4]);
        end
        chk("rr eject_count", 64'(ifa.eject_count), 64'd13);
        drain();

        // Backpressure to full, then one pop+push at full
        for (int i = 0; i < 4; i++) rrf[i] = mk(1, 8'd0, 48'hB0 + 48'(i));
        set4(4'b1111, rrf[0], rrf[1], rrf[2], rrf[3]);
        #2;
        chk("bp grant0", 64'(ifa.eject_grant), 64'b0001);
        cyc();
        #2;
        chk("bp grant1", 64'(ifa.eject_grant), 64'b0010);
        cyc();
        chk("bp fifo_full", 64'(ifa.fifo_full), 64'd1);
        #2;
        chk("bp full grant", 64'(ifa.eject_grant), 64'b0000);
        ifa.pe_ready = 1'b1;
        #1;
        chk("bp poppush grant", 64'(ifa.eject_grant), 64'b0100);
        cyc();
        ifa.pe_ready = 1'b0;
        chk("bp still full", 64'(ifa.fifo_full), 64'd1);
        chk("bp head order", ifa.pe_flit, rrf[1]);
        chk("bp eject_count", 64'(ifa.eject_count), 64'd16);
        drain();

        // Non-local inputs are ignored
        set4(4'b1111, mk(0, 8'd7, 48'hC0), mk(0, 8'd7, 48'hC1), mk(0, 8'd7, 48'hC2), mk(0, 8'd7, 48'hC3));
        #2;
        chk("nonlocal grant", 64'(ifa.eject_grant), 64'b0000);
        cyc();
        ifa.in_valid = 4'b0000;
        chk("nonlocal count", 64'(ifa.eject_count), 64'd16);
        chk("nonlocal pe_valid", 64'(ifa.pe_valid), 64'd0);

        // Run the counter up to 0xFFFD, then fill the FIFO to reach 0xFFFF
        ifa.pe_ready = 1'b1;
        set4(4'b0001, mk(1, 8'd0, 48'hC0), 64'h0, 64'h0, 64'h0);
        guard = 0;
        while (m_cnt != 32'hFFFD && guard < 70000) begin
            cyc();
            guard++;
        end
        if (guard >= 70000) chk("count ramp timeout", 64'(m_cnt), 64'hFFFD);
        drain();
        ifa.in_valid = 4'b0001;
        cyc();
        cyc();
        ifa.in_valid = 4'b0000;
        chk("pre a count", 64'(ifa.eject_count), 64'hFFFF);
        chk("pre a full", 64'(ifa.fifo_full), 64'd1);
        chk("pre b count", 64'(ifb.eject_count), 64'hFFFF);
        chk("pre b full", 64'(ifb.fifo_full), 64'd1);

        // Instance A reset mid-transfer; instance B pops and pushes across the wrap
        set4(4'b0001, mk(1, 8'd0, 48'hD0), 64'h0, 64'h0, 64'h0);
        rst_a = 1'b0;
        ifa.pe_ready = 1'b1;
        #2;
        chk("rst a grant", 64'(ifa.eject_grant), 64'b0000);
        chk("wrap b grant", 64'(ifb.eject_grant), 64'b0001);
        cyc();
        rst_a = 1'b1;
        ifa.pe_ready = 1'b0;
        ifa.in_valid = 4'b0000;
        chk("rst a pe_valid", 64'(ifa.pe_valid), 64'd0);
        chk("rst a fifo_full", 64'(ifa.fifo_full), 64'd0);
        chk("rst a count", 64'(ifa.eject_count), 64'd0);
        chk("rst a pe_flit", ifa.pe_flit, 64'd0);
        chk("wrap b count", 64'(ifb.eject_count), 64'd0);
        chk("wrap b full", 64'(ifb.fifo_full), 64'd1);
        chk("wrap b pe_flit", ifb.pe_flit, mk(1, 8'd0, 48'hC0));
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/eject_scheduler.md
Name: eject_scheduler

Overview:
- Controls local ejection at a router node.
- Each cycle it selects at most one of the four incoming flits destined for the local PE. The oldest flit wins; equal ages are broken by a rotating round-robin pointer.
- The winner is pushed into a small ejection FIFO drained by the PE through a valid/ready handshake.
- A one-hot grant tells the router datapath which input was ejected. Every other local-bound flit stays in the deflection path.

Parameters:
- FLIT_W, 64, flit width in bits.
- LOCAL_BIT, 0, bit index of the local-destination (productive-port) flag in the flit.
- AGE_LSB, 8, LSB of the age field in the flit.
- AGE_W, 8, width of the age field; a larger value means older.
- DEPTH, 2, ejection FIFO depth (power of two, at least 2).
- CNT_W, 16, width of the ejection statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- flit_in0..flit_in3  in  FLIT_W each  flits arriving at the ejection stage.
- in_valid  in  4  bit i=1 means flit_in i holds a flit.
- eject_grant  out  4  one-hot (or zero) index of the ejected input; combinational, same cycle.
- pe_flit  out  FLIT_W  head flit of the FIFO.
- pe_valid  out  1  FIFO non-empty.
- pe_ready  in  1  PE accepts pe_flit this cycle.
- fifo_full  out  1  occupancy equals DEPTH.
- eject_count  out  CNT_W  total flits ejected since reset; wraps modulo 2^CNT_W.

Behaviour:
- Request: req[i] = in_valid[i] & flit_in i[LOCAL_BIT].
- can_push: asserted when occupancy < DEPTH, or when occupancy == DEPTH and a pop occurs this cycle (pe_valid & pe_ready).
- Arbitration (combinational):
  - If can_push=0 or req=0, eject_grant=0.
  - Otherwise, grant the requester with the maximum age field.
  - Among requesters tied on maximum age, grant the first found scanning from rr_ptr upward, modulo 4.
  - Exactly one grant bit is set.
- rr_ptr (2 bits): on a cycle with a grant to index g, rr_ptr <= (g+1) mod 4. Otherwise rr_ptr holds. Reset value 0.
- FIFO:
  - Push occurs on a granted cycle: the granted flit is written at wr_ptr.
  - Pop occurs when pe_valid & pe_ready.
  - Push and pop in the same cycle leave occupancy unchanged; this is legal at occupancy DEPTH (can_push rule) and at occupancy 0 only if pe_valid (i.e. never at 0).
  - Pointers wrap modulo DEPTH.
- Latency: a granted flit appears on pe_flit with pe_valid=1 on the cycle after the grant, if the FIFO was empty. There is no same-cycle bypass.
- Ordering: pe_flit is stable while pe_valid=1 and pe_ready=0. Output order equals grant order.
- eject_count increments by 1 on every push and wraps from 2^CNT_W-1 to 0.
- fifo_full = (occupancy == DEPTH).
- Non-granted local requests are not stored. The router deflects them; this block takes no action on them.
- in_valid bits with LOCAL_BIT=0 are ignored.
- Reset (reset=0 at a clock edge) has priority over all other activity, including mid-transfer:
  - occupancy, wr_ptr, rd_ptr, rr_ptr and eject_count go to 0.
  - pe_valid=0 and fifo_full=0.
  - pe_flit = 0 (the FIFO storage read mux is gated by pe_valid).
  - eject_grant=0 while reset is asserted.
  - Any in-flight flit is discarded.

Test Plan:
- Reset then single request: reset low 2 cycles, then release. Apply in_valid=4'b0100 with flit2 local=1, age=5 → eject_grant=4'b0100 the same cycle; next cycle pe_valid=1, pe_flit=flit2, eject_count=1, rr_ptr=3.
- Age priority: all four inputs local, ages 3, 9, 9, 1, rr_ptr=0 → grant 4'b0010. Repeat the same stimulus with rr_ptr=2 → grant 4'b0100.
- Round-robin fairness: all four inputs local with equal age 0, pe_ready=1, 8 cycles → grant sequence 0,1,2,3,0,1,2,3; eject_count=8; pe_flit order matches.
- Backpressure and full: pe_ready=0 with continuous local requests → 2 pushes, then fifo_full=1 and eject_grant=0. Raise pe_ready=1 for one cycle with a request present → pop and push in the same cycle; occupancy stays 2; order is preserved.
- Non-local filter: in_valid=4'hF with all LOCAL_BIT=0 → eject_grant=0, no push, eject_count unchanged.
- Reset mid-operation: FIFO holding 2 flits, eject_count=0xFFFF (CNT_W=16), assert reset for one edge → pe_valid=0, fifo_full=0, eject_count=0. Separately, without reset, one push from 0xFFFF → eject_count=0x0000.
